// File: rtl/pipeline_hazard_controller_if.sv
// Hazard-control bundle between the pipeline datapath and the hazard controller.
//   master : datapath side - drives ID/EX hazard inputs, receives enables/flushes/status
//   slave  : controller side - receives hazard inputs, drives enables/flushes/status
// Signals:
//   rs1_id, rs2_id, use_rs1_id, use_rs2_id : ID-stage source operands and their use flags
//   rd_ex, memread_ex, branch_taken_ex      : EX-stage destination, load flag, taken redirect
//   mem_busy                                : data memory not ready this cycle
//   pc_write, ifid_write, idex_write, exmem_write : pipeline register write enables
//   ifid_flush, idex_flush                  : insert bubble into IF/ID or ID/EX
//   mem_timeout                             : sticky memory-wait watchdog error
//   stall_cycles                            : saturating count of stalled cycles
interface pipeline_hazard_controller_if;
  logic [4:0]  rs1_id;
  logic [4:0]  rs2_id;
  logic        use_rs1_id;
  logic        use_rs2_id;
  logic [4:0]  rd_ex;
  logic        memread_ex;
  logic        branch_taken_ex;
  logic        mem_busy;
  logic        pc_write;
  logic        ifid_write;
  logic        idex_write;
  logic        exmem_write;
  logic        ifid_flush;
  logic        idex_flush;
  logic        mem_timeout;
  logic [15:0] stall_cycles;

  modport master (
    output rs1_id, rs2_id, use_rs1_id, use_rs2_id, rd_ex, memread_ex,
           branch_taken_ex, mem_busy,
    input  pc_write, ifid_write, idex_write, exmem_write, ifid_flush,
           idex_flush, mem_timeout, stall_cycles
  );

  modport slave (
    input  rs1_id, rs2_id, use_rs1_id, use_rs2_id, rd_ex, memread_ex,
           branch_taken_ex, mem_busy,
    output pc_write, ifid_write, idex_write, exmem_write, ifid_flush,
           idex_flush, mem_timeout, stall_cycles
  );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Pipeline hazard controller: resolves load-use stalls, taken-branch flushes and
// data-memory wait freezes, with a memory-wait watchdog and a stall counter.
// Ports:
//   clk   : clock, all state updates on rising edge
//   rst_n : synchronous active-low reset
//   hz    : hazard bundle (slave side), see pipeline_hazard_controller_if
module pipeline_hazard_controller (
  input logic                           clk,
  input logic                           rst_n,
  pipeline_hazard_controller_if.slave   hz
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_wait_cnt;
  logic [7:0]  w_wait_cnt_nxt;
  logic        r_mem_timeout;
  logic        w_timeout_set;
  logic [15:0] r_stall_cycles;

  logic w_lu;
  logic w_pc_write;
  logic w_ifid_write;
  logic w_idex_write;
  logic w_exmem_write;
  logic w_ifid_flush;
  logic w_idex_flush;

  // Load-use: EX load writes a register the ID instruction actually reads (x0 excluded).
  always_comb begin
    w_lu = hz.memread_ex && (hz.rd_ex != 5'd0) &&
           ((hz.use_rs1_id && (hz.rd_ex == hz.rs1_id)) ||
            (hz.use_rs2_id && (hz.rd_ex == hz.rs2_id)));
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    w_timeout_set  = 1'b0;
    w_pc_write     = 1'b0;
    w_ifid_write   = 1'b0;
    w_idex_write   = 1'b0;
    w_exmem_write  = 1'b0;
    w_ifid_flush   = 1'b0;
    w_idex_flush   = 1'b0;

    if (!rst_n) begin
      w_ifid_flush = 1'b1;
      w_idex_flush = 1'b1;
    end else begin
      unique case (r_state)
        RUN, MEM_WAIT: begin
          if (hz.mem_busy) begin
            if (r_state == RUN) begin
              w_state_nxt    = MEM_WAIT;
              w_wait_cnt_nxt = 8'd1;
            end else if (r_wait_cnt == 8'hFF) begin
              w_state_nxt   = ERROR;
              w_timeout_set = 1'b1;
            end else begin
              w_wait_cnt_nxt = r_wait_cnt + 8'd1;
            end
          end else begin
            // Memory free: the frozen EX stage re-presents any branch, so both RUN
            // and the MEM_WAIT exit cycle resolve hazards identically.
            w_state_nxt    = RUN;
            w_wait_cnt_nxt = '0;
            if (hz.branch_taken_ex) begin
              w_pc_write    = 1'b1;
              w_ifid_write  = 1'b1;
              w_idex_write  = 1'b1;
              w_exmem_write = 1'b1;
              w_ifid_flush  = 1'b1;
              w_idex_flush  = 1'b1;
            end else if (w_lu) begin
              w_idex_write  = 1'b1;
              w_exmem_write = 1'b1;
              w_idex_flush  = 1'b1;
            end else begin
              w_pc_write    = 1'b1;
              w_ifid_write  = 1'b1;
              w_idex_write  = 1'b1;
              w_exmem_write = 1'b1;
            end
          end
        end
        ERROR: begin
          w_state_nxt = ERROR;
        end
        default: begin
          w_state_nxt    = RUN;
          w_wait_cnt_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= RUN;
      r_wait_cnt     <= '0;
      r_mem_timeout  <= 1'b0;
      r_stall_cycles <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      if (w_timeout_set) begin
        r_mem_timeout <= 1'b1;
      end
      if (!w_pc_write && (r_state != ERROR) && (r_stall_cycles != '1)) begin
        r_stall_cycles <= r_stall_cycles + 16'd1;
      end
    end
  end

  assign hz.pc_write     = w_pc_write;
  assign hz.ifid_write   = w_ifid_write;
  assign hz.idex_write   = w_idex_write;
  assign hz.exmem_write  = w_exmem_write;
  assign hz.ifid_flush   = w_ifid_flush;
  assign hz.idex_flush   = w_idex_flush;
  assign hz.mem_timeout  = r_mem_timeout;
  assign hz.stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed self-checking bench for pipeline_hazard_controller.
// Control vector layout: {pc_write, ifid_write, idex_write, exmem_write, ifid_flush, idex_flush}
module tb_pipeline_hazard_controller;

  localparam logic [5:0] C_RUN    = 6'b1111_00;
  localparam logic [5:0] C_FREEZE = 6'b0000_00;
  localparam logic [5:0] C_BRANCH = 6'b1111_11;
  localparam logic [5:0] C_LU     = 6'b0011_01;
  localparam logic [5:0] C_RST    = 6'b0000_11;

  typedef struct {
    logic        rstn;
    logic [5:0]  ctl;
    logic        to;
    logic [15:0] stall;
    string       tag;
  } exp_t;

  logic clk;
  logic rst_n;
  pipeline_hazard_controller_if bus ();

  pipeline_hazard_controller u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (bus)
  );

  logic [5:0] w_ctl;
  assign w_ctl = {bus.pc_write, bus.ifid_write, bus.idex_write, bus.exmem_write,
                  bus.ifid_flush, bus.idex_flush};

  exp_t        sb[$];
  int unsigned n_vec;
  int unsigned n_err;
  logic [15:0] exp_stall;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cycle(input logic rstn, input logic busy, input logic br, input logic mr,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2,
                       input logic [5:0] ectl, input logic eto, input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n               = rstn;
    bus.mem_busy        = busy;
    bus.branch_taken_ex = br;
    bus.memread_ex      = mr;
    bus.rd_ex           = rd;
    bus.rs1_id          = rs1;
    bus.use_rs1_id      = u1;
    bus.rs2_id          = rs2;
    bus.use_rs2_id      = u2;
    sb.push_back('{rstn: rstn, ctl: ectl, to: eto, stall: exp_stall, tag: tag});
    @(negedge clk);
    e = sb.pop_front();
    n_vec++;
    assert (w_ctl === e.ctl) else begin
      n_err++;
      $error("FAIL %s ctl got %b want %b", e.tag, w_ctl, e.ctl);
    end
    n_vec++;
    assert (bus.mem_timeout === e.to) else begin
      n_err++;
      $error("FAIL %s mem_timeout got %b want %b", e.tag, bus.mem_timeout, e.to);
    end
    n_vec++;
    assert (bus.stall_cycles === e.stall) else begin
      n_err++;
      $error("FAIL %s stall_cycles got %h want %h", e.tag, bus.stall_cycles, e.stall);
    end
    // Expected count for the next cycle: stalls counted only outside ERROR.
    if (!e.rstn) exp_stall = '0;
    else if (!e.ctl[5] && !e.to && (exp_stall != 16'hFFFF)) exp_stall = exp_stall + 16'd1;
  endtask

  // Cycle with no register hazards in flight.
  task automatic simple(input logic busy, input logic br, input logic [5:0] ectl,
                        input logic eto, input string tag);
    cycle(1'b1, busy, br, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, ectl, eto, tag);
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    exp_stall = '0;
    rst_n               = 1'b0;
    bus.mem_busy        = 1'b0;
    bus.branch_taken_ex = 1'b0;
    bus.memread_ex      = 1'b0;
    bus.rd_ex           = '0;
    bus.rs1_id          = '0;
    bus.use_rs1_id      = 1'b0;
    bus.rs2_id          = '0;
    bus.use_rs2_id      = 1'b0;

    // Reset
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, C_RST, 1'b0, "reset");
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, C_RST, 1'b0, "reset_inputs");
    simple(1'b0, 1'b0, C_RUN, 1'b0, "run_idle");

    // Load-use on rs2, then normal
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 5'd0, 1'b0, 5'd5, 1'b1, C_LU, 1'b0, "lu_rs2");
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 5'd5, 5'd0, 1'b0, 5'd5, 1'b1, C_RUN, 1'b0, "after_lu");
    // Load-use on rs1
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 5'd9, 5'd9, 1'b1, 5'd3, 1'b1, C_LU, 1'b0, "lu_rs1");
    // Match but operand not used
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 5'd9, 5'd9, 1'b0, 5'd9, 1'b0, C_RUN, 1'b0, "no_use");
    // rd_ex = x0 never hazards
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, C_RUN, 1'b0, "rd_zero");
    // Branch beats load-use
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 5'd7, 5'd7, 1'b1, 5'd0, 1'b0, C_BRANCH, 1'b0, "br_and_lu");
    simple(1'b0, 1'b1, C_BRANCH, 1'b0, "branch");

    // Memory wait: 3 busy cycles, exit with branch
    simple(1'b1, 1'b1, C_FREEZE, 1'b0, "mw_enter");
    simple(1'b1, 1'b1, C_FREEZE, 1'b0, "mw_wait1");
    simple(1'b1, 1'b1, C_FREEZE, 1'b0, "mw_wait2");
    simple(1'b0, 1'b1, C_BRANCH, 1'b0, "mw_exit_br");
    simple(1'b0, 1'b0, C_RUN, 1'b0, "mw_run");
    // Memory wait exit with load-use pending
    simple(1'b1, 1'b0, C_FREEZE, 1'b0, "mw2_enter");
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 5'd4, 5'd4, 1'b1, 5'd0, 1'b0, C_LU, 1'b0, "mw2_exit_lu");
    simple(1'b0, 1'b0, C_RUN, 1'b0, "mw2_run");

    // Watchdog: RUN cycle + 255 MEM_WAIT cycles, then ERROR
    for (int i = 1; i <= 300; i++) begin
      simple(1'b1, 1'b0, C_FREEZE, (i >= 257), "watchdog");
    end
    simple(1'b0, 1'b1, C_FREEZE, 1'b1, "error_sticky");
    simple(1'b0, 1'b0, C_FREEZE, 1'b1, "error_hold");
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, C_RST, 1'b1, "error_reset");
    simple(1'b0, 1'b0, C_RUN, 1'b0, "post_error_run");

    // Reset mid-wait leaves no residual count: 200 + 200 busy cycles stay below timeout
    for (int i = 0; i < 200; i++) simple(1'b1, 1'b0, C_FREEZE, 1'b0, "pre_rst_wait");
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, C_RST, 1'b0, "mid_wait_reset");
    for (int i = 0; i < 200; i++) simple(1'b1, 1'b0, C_FREEZE, 1'b0, "post_rst_wait");
    simple(1'b0, 1'b0, C_RUN, 1'b0, "post_rst_run");

    // Saturation: bursts of 250 busy cycles separated by one free cycle
    for (int k = 0; k < 263; k++) begin
      for (int i = 0; i < 250; i++) simple(1'b1, 1'b0, C_FREEZE, 1'b0, "sat_wait");
      simple(1'b0, 1'b0, C_RUN, 1'b0, "sat_free");
    end
    for (int i = 0; i < 5; i++) simple(1'b1, 1'b0, C_FREEZE, 1'b0, "sat_hold");
    simple(1'b0, 1'b0, C_RUN, 1'b0, "sat_final");
    n_vec++;
    assert (bus.stall_cycles === 16'hFFFF) else begin
      n_err++;
      $error("FAIL sat_max stall_cycles got %h want ffff", bus.stall_cycles);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_controller.md
PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port rst_n, input, 1 bit: the reset, synchronous and active-low.
REQ-003 The block SHALL have ports rs1_id and rs2_id, input, 5 bits each: source registers of the instruction in ID.
REQ-004 The block SHALL have ports use_rs1_id and use_rs2_id, input, 1 bit each: the ID instruction actually reads rs1/rs2.
REQ-005 The block SHALL have port rd_ex, input, 5 bits: destination register of the instruction in EX.
REQ-006 The block SHALL have port memread_ex, input, 1 bit: the EX instruction is a load.
REQ-007 The block SHALL have port branch_taken_ex, input, 1 bit: a branch or jump resolved taken in EX.
REQ-008 The block SHALL have port mem_busy, input, 1 bit: data memory is not ready this cycle.
REQ-009 The block SHALL have ports pc_write, ifid_write, idex_write and exmem_write, output, 1 bit each: register write enables.
REQ-010 The block SHALL have ports ifid_flush and idex_flush, output, 1 bit each: load a bubble (NOP) into IF/ID or ID/EX.
REQ-011 The block SHALL have port mem_timeout, output, 1 bit: sticky memory-wait watchdog error.
REQ-012 The block SHALL have port stall_cycles, output, 16 bits: saturating count of stalled cycles.

Function
REQ-013 The block SHALL implement state register {RUN, MEM_WAIT, ERROR} plus an 8-bit wait_cnt.
REQ-014 Outputs SHALL be combinational in current state and inputs; state, wait_cnt, mem_timeout and stall_cycles SHALL be registered.
REQ-015 Load-use hazard (lu) SHALL be: memread_ex=1, rd_ex!=0, and ((use_rs1_id and rd_ex==rs1_id) or (use_rs2_id and rd_ex==rs2_id)).
REQ-016 In RUN with mem_busy=1, the block SHALL output all four write enables 0 and both flushes 0, go to MEM_WAIT, and set wait_cnt=1.
REQ-017 In RUN with mem_busy=0 and branch_taken_ex=1, the block SHALL output all writes 1 and ifid_flush=1, idex_flush=1; branch SHALL take priority over lu.
REQ-018 In RUN with mem_busy=0, branch_taken_ex=0 and lu=1, the block SHALL output pc_write=0, ifid_write=0, idex_write=1, idex_flush=1, exmem_write=1 (exactly one bubble; no state change).
REQ-019 In RUN with no condition, the block SHALL output all writes 1 and flushes 0.
REQ-020 In MEM_WAIT with mem_busy=1, the block SHALL freeze all writes and flushes at 0 and increment wait_cnt.
REQ-021 If wait_cnt==255 and mem_busy=1 in MEM_WAIT, the next state SHALL be ERROR and mem_timeout SHALL be set.
REQ-022 In MEM_WAIT with mem_busy=0, the block SHALL evaluate outputs exactly per REQ-017..019 in that cycle, return to RUN, and clear wait_cnt.
REQ-023 branch_taken_ex held during MEM_WAIT SHALL NOT be latched separately; the frozen EX stage re-presents it on exit.
REQ-024 ERROR SHALL freeze all writes and flushes at 0, hold mem_timeout=1, and be left only by reset.
REQ-025 stall_cycles SHALL increment by 1 on each cycle with rst_n=1, pc_write=0 and state!=ERROR, and SHALL saturate at 0xFFFF.

Reset
REQ-026 When rst_n=0 at a rising edge, the block SHALL set state=RUN, wait_cnt=0, mem_timeout=0 and stall_cycles=0.
REQ-027 While rst_n=0, outputs SHALL be pc_write=0, ifid_write=0, idex_write=0, exmem_write=0, ifid_flush=1 and idex_flush=1, regardless of state.
REQ-028 Reset asserted mid-MEM_WAIT or in ERROR SHALL take effect at the next edge with no residual wait count.

Verification
REQ-029 The bench SHALL cover load-use: memread_ex=1, rd_ex=5, rs2_id=5, use_rs2_id=1 -> one cycle of pc_write=0, ifid_write=0, idex_flush=1; stall_cycles +1.
REQ-030 The bench SHALL cover rd_ex=0 with a matching rs1: memread_ex=1, rd_ex=0, rs1_id=0 -> no stall, all writes 1.
REQ-031 The bench SHALL cover simultaneous events: branch_taken_ex=1 and lu=1 -> ifid_flush=1, idex_flush=1, pc_write=1, no stall.
REQ-032 The bench SHALL cover a memory wait: mem_busy high 3 cycles then low with branch_taken_ex=1 -> 3 frozen cycles, then a flush cycle, RUN; stall_cycles +3.
REQ-033 The bench SHALL cover the watchdog: mem_busy held 300 cycles -> ERROR after 255 MEM_WAIT cycles, mem_timeout=1 sticky; rst_n=0 one edge clears it.
REQ-034 The bench SHALL cover saturation: stall_cycles preloaded near max by sustained mem_busy -> holds 0xFFFF, no wrap.
